// File: rtl/bcd_serial_addsub_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam int BCD_MAX     = 9;

   function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
      return d > BCD_DIGIT_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle; master drives operands, slave returns the result.
interface bcd_serial_addsub_if #(parameter int DIGITS = 4);

   logic                  start_valid;
   logic                  start_ready;
   logic [4*DIGITS-1:0]   op_a;
   logic [4*DIGITS-1:0]   op_b;
   logic                  cin;
   logic                  sub;
   logic                  res_valid;
   logic                  res_ready;
   logic [4*DIGITS-1:0]   sum;
   logic                  cout;
   logic                  err;

   modport master (
      output start_valid, op_a, op_b, cin, sub, res_ready,
      input  start_ready, res_valid, sum, cout, err
   );

   modport slave (
      input  start_valid, op_a, op_b, cin, sub, res_ready,
      output start_ready, res_valid, sum, cout, err
   );

endinterface

// File: rtl/bcd_serial_addsub_digit_add.sv
// Single-digit BCD add; in subtract mode B is nine's-complemented before the add.
import bcd_serial_addsub_pkg::*;

module bcd_digit_add (
   input  logic [BCD_DIGIT_W-1:0] a_d,
   input  logic [BCD_DIGIT_W-1:0] b_d,
   input  logic                   sub,
   input  logic                   c_in,
   output logic [BCD_DIGIT_W-1:0] digit,
   output logic                   c_out
);

   logic [BCD_DIGIT_W-1:0] b_eff;
   logic [BCD_DIGIT_W:0]   raw;
   logic [BCD_DIGIT_W:0]   adj;

   // Out-of-range B digits wrap mod 16 here, matching the plain digit rule.
   assign b_eff = sub ? (BCD_DIGIT_W'(BCD_MAX) - b_d) : b_d;
   assign raw   = {1'b0, a_d} + {1'b0, b_eff} + {{BCD_DIGIT_W{1'b0}}, c_in};
   assign adj   = raw + (BCD_DIGIT_W+1)'(6);

   always_comb begin
      digit = raw[BCD_DIGIT_W-1:0];
      c_out = 1'b0;
      if (raw > (BCD_DIGIT_W+1)'(BCD_MAX)) begin
         digit = adj[BCD_DIGIT_W-1:0];
         c_out = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD add/subtract, one digit per cycle, LSD first.
import bcd_serial_addsub_pkg::*;

module bcd_serial_addsub #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   bcd_serial_addsub_if.slave  bus
);

   localparam int W  = BCD_DIGIT_W * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   state_t                 state, state_nx;
   logic [W-1:0]           a_q, b_q, sum_q;
   logic                   sub_q, carry_q, err_q;
   logic [CW-1:0]          cnt_q;
   logic [BCD_DIGIT_W-1:0] digit;
   logic                   c_nx;
   logic                   accept, last;

   assign accept = bus.start_valid && (state == IDLE);
   assign last   = (cnt_q == CW'(DIGITS - 1));

   // Operands shift right each cycle so the adder always sees the low digit.
   bcd_digit_add u_dig (
      .a_d   (a_q[BCD_DIGIT_W-1:0]),
      .b_d   (b_q[BCD_DIGIT_W-1:0]),
      .sub   (sub_q),
      .c_in  (carry_q),
      .digit (digit),
      .c_out (c_nx)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start_valid) state_nx = RUN;
         RUN:     if (last)            state_nx = DONE;
         DONE:    if (bus.res_ready)   state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= bus.op_a;
         b_q     <= bus.op_b;
         sub_q   <= bus.sub;
         carry_q <= bus.sub ? 1'b1 : bus.cin;
         sum_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (state == RUN) begin
         a_q     <= a_q >> BCD_DIGIT_W;
         b_q     <= b_q >> BCD_DIGIT_W;
         // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
         sum_q   <= (sum_q >> BCD_DIGIT_W) | (W'(digit) << (W - BCD_DIGIT_W));
         carry_q <= c_nx;
         cnt_q   <= cnt_q + CW'(1);
         if (digit_bad(a_q[BCD_DIGIT_W-1:0]) || digit_bad(b_q[BCD_DIGIT_W-1:0]))
            err_q <= 1'b1;
      end
   end

   assign bus.start_ready = (state == IDLE);
   assign bus.res_valid   = (state == DONE);
   assign bus.sum         = sum_q;
   assign bus.cout        = carry_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed cases plus random traffic vs a decimal model.
module tb_bcd_serial_addsub;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bcd_serial_addsub_if #(.DIGITS(4)) bus4 ();
   bcd_serial_addsub_if #(.DIGITS(1)) bus1 ();

   bcd_serial_addsub #(.DIGITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
   bcd_serial_addsub #(.DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint bcd2int(input logic [15:0] v);
      longint r = 0;
      for (int i = 3; i >= 0; i--) r = r * 10 + longint'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [15:0] int2bcd(input longint v);
      logic [15:0] r = '0;
      longint      t = v;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Decimal-arithmetic reference for valid 4-digit operands.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic s, output logic [15:0] es, output logic ec);
      longint av = bcd2int(a);
      longint bv = bcd2int(b);
      longint t;
      if (s) begin
         ec = (av >= bv);
         t  = ec ? av - bv : 10000 + av - bv;
      end else begin
         t  = av + bv + longint'(ci);
         ec = (t >= 10000);
         t  = t % 10000;
      end
      es = int2bcd(t);
   endtask

   function automatic logic [15:0] rand_bcd();
      logic [15:0] r;
      for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(9));
      return r;
   endfunction

   // Offers one operand set, waits for the result, completes the handshake.
   task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic ci,
                      input logic s, output logic [15:0] rs, output logic rc,
                      output logic re, output int lat);
      @(negedge clk);
      bus4.start_valid = 1'b1;
      bus4.op_a = a; bus4.op_b = b; bus4.cin = ci; bus4.sub = s;
      @(posedge clk); #1;
      bus4.start_valid = 1'b0;
      bus4.op_a = 16'h5A5A; bus4.op_b = 16'hA5A5; bus4.cin = ~ci; bus4.sub = ~s;
      lat = 0;
      while (!bus4.res_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      rs = bus4.sum; rc = bus4.cout; re = bus4.err;
      @(negedge clk); bus4.res_ready = 1'b1;
      @(posedge clk); #1;
      bus4.res_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] rs, es, a, b, hs;
      logic        rc, ec, re, ci, s, hc, he;
      int          lat;

      bus4.start_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
      bus4.cin = 1'b0; bus4.sub = 1'b0; bus4.res_ready = 1'b0;
      bus1.start_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
      bus1.cin = 1'b0; bus1.sub = 1'b0; bus1.res_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", 64'(bus4.start_ready), 64'd1);
      chk("rst_res_valid",   64'(bus4.res_valid),   64'd0);
      chk("rst_sum",         64'(bus4.sum),         64'd0);
      chk("rst_cout",        64'(bus4.cout),        64'd0);
      chk("rst_err",         64'(bus4.err),         64'd0);
      @(negedge clk); rst = 1'b0;

      txn(16'h9999, 16'h0001, 1'b0, 1'b0, rs, rc, re, lat);
      chk("wrap_lat",  64'(lat), 64'd4);
      chk("wrap_sum",  64'(rs),  64'h0000);
      chk("wrap_cout", 64'(rc),  64'd1);
      chk("wrap_err",  64'(re),  64'd0);

      txn(16'h1234, 16'h5678, 1'b1, 1'b0, rs, rc, re, lat);
      chk("add_sum",  64'(rs), 64'h6913);
      chk("add_cout", 64'(rc), 64'd0);

      txn(16'h0500, 16'h0123, 1'b0, 1'b1, rs, rc, re, lat);
      chk("subpos_sum",  64'(rs), 64'h0377);
      chk("subpos_cout", 64'(rc), 64'd1);

      txn(16'h0123, 16'h0500, 1'b1, 1'b1, rs, rc, re, lat);
      chk("subneg_sum",  64'(rs), 64'h9623);
      chk("subneg_cout", 64'(rc), 64'd0);

      txn(16'h000A, 16'h0000, 1'b0, 1'b0, rs, rc, re, lat);
      chk("bad_err", 64'(re), 64'd1);
      chk("bad_sum", 64'(rs), 64'h0010);

      txn(16'h0042, 16'h0007, 1'b0, 1'b0, rs, rc, re, lat);
      chk("err_clear", 64'(re), 64'd0);
      chk("after_bad_sum", 64'(rs), 64'h0049);

      for (int n = 0; n < 24; n++) begin
         a  = rand_bcd();
         b  = rand_bcd();
         ci = 1'($urandom_range(1));
         s  = 1'($urandom_range(1));
         model(a, b, ci, s, es, ec);
         txn(a, b, ci, s, rs, rc, re, lat);
         chk($sformatf("rnd%0d_sum", n),  64'(rs),  64'(es));
         chk($sformatf("rnd%0d_cout", n), 64'(rc),  64'(ec));
         chk($sformatf("rnd%0d_err", n),  64'(re),  64'd0);
         chk($sformatf("rnd%0d_lat", n),  64'(lat), 64'd4);
      end

      // Result held under back-pressure while new offers are ignored.
      @(negedge clk);
      bus4.start_valid = 1'b1; bus4.op_a = 16'h2500; bus4.op_b = 16'h0750;
      bus4.cin = 1'b0; bus4.sub = 1'b0;
      @(posedge clk); #1;
      bus4.start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("hold_valid", 64'(bus4.res_valid), 64'd1);
      hs = bus4.sum; hc = bus4.cout; he = bus4.err;
      chk("hold_sum0", 64'(hs), 64'h3250);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus4.start_valid = 1'(k % 2 == 0);
         bus4.op_a = 16'h9999; bus4.op_b = 16'h9999; bus4.cin = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("hold%0d_sum", k),   64'(bus4.sum),         64'h3250);
         chk($sformatf("hold%0d_cout", k),  64'(bus4.cout),        64'(hc));
         chk($sformatf("hold%0d_err", k),   64'(bus4.err),         64'(he));
         chk($sformatf("hold%0d_valid", k), 64'(bus4.res_valid),   64'd1);
         chk($sformatf("hold%0d_sready", k), 64'(bus4.start_ready), 64'd0);
      end
      @(negedge clk); bus4.start_valid = 1'b0; bus4.res_ready = 1'b1;
      @(posedge clk); #1;
      bus4.res_ready = 1'b0;
      chk("hs_idle_ready", 64'(bus4.start_ready), 64'd1);
      chk("hs_idle_valid", 64'(bus4.res_valid),   64'd0);

      // Reset during the second RUN cycle aborts the operation.
      @(negedge clk);
      bus4.start_valid = 1'b1; bus4.op_a = 16'h8888; bus4.op_b = 16'h7777;
      bus4.cin = 1'b1; bus4.sub = 1'b0;
      @(posedge clk); #1;
      bus4.start_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_ready", 64'(bus4.start_ready), 64'd1);
      chk("abort_valid", 64'(bus4.res_valid),   64'd0);
      chk("abort_sum",   64'(bus4.sum),         64'd0);
      chk("abort_cout",  64'(bus4.cout),        64'd0);
      chk("abort_err",   64'(bus4.err),         64'd0);
      @(negedge clk); rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("abort_no_valid", 64'(bus4.res_valid), 64'd0);
      txn(16'h4321, 16'h1111, 1'b0, 1'b1, rs, rc, re, lat);
      chk("post_abort_sum",  64'(rs), 64'h3210);
      chk("post_abort_cout", 64'(rc), 64'd1);

      // Single-digit instance: 9 + 9 + 1.
      @(negedge clk);
      bus1.start_valid = 1'b1; bus1.op_a = 4'h9; bus1.op_b = 4'h9;
      bus1.cin = 1'b1; bus1.sub = 1'b0;
      @(posedge clk); #1;
      bus1.start_valid = 1'b0;
      chk("d1_busy", 64'(bus1.res_valid), 64'd0);
      @(posedge clk); #1;
      chk("d1_valid", 64'(bus1.res_valid), 64'd1);
      chk("d1_sum",   64'(bus1.sum),       64'h9);
      chk("d1_cout",  64'(bus1.cout),      64'd1);
      @(negedge clk); bus1.res_ready = 1'b1;
      @(posedge clk); #1;
      bus1.res_ready = 1'b0;
      chk("d1_idle", 64'(bus1.start_ready), 64'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
